// File: rtl/flopoco_fadd_result_capture.sv
// Receive-side companion for a fixed-latency FloPoCo adder core.
// Tracks issued operand pairs with a token shift register, captures the core
// result when its token leaves the pipe, and queues it in a FWFT FIFO.
// Issue is credit-throttled so a captured result always finds a free slot.
module flopoco_fadd_result_capture #(
  parameter int WE      = 4,
  parameter int WF      = 4,
  parameter int W       = WE + WF + 3,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 core_r,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  output logic [1:0]                   out_exn,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic [15:0]                  nan_count,
  output logic                         overflow
);

  localparam int IW = $clog2(LATENCY + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Saturating increment for the NaN event counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0] vld_nxt;
  logic [IW-1:0]      inflight_q;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CW-1:0]      cnt;
  logic [W-1:0]       mem [DEPTH];

  logic fire;
  logic cap;
  logic full;
  logic wr;
  logic pop;
  logic cap_nan;

  // Credit: every issued-but-unconsumed result owns a FIFO slot, so the sum of
  // tokens in flight and queued entries bounds new issue. Registered state only.
  assign in_ready  = ({{(32-IW){1'b0}}, inflight_q} + {{(32-CW){1'b0}}, cnt}) < DEPTH;
  assign fire      = in_valid & in_ready;
  assign cap       = vld_sr[LATENCY-1];
  assign full      = (cnt == CW'(DEPTH));
  assign wr        = cap & ~full;
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & out_ready;
  assign cap_nan   = (core_r[W-1:W-2] == 2'b11);

  assign out_data  = mem[rptr];
  assign out_exn   = out_data[W-1:W-2];
  assign inflight  = inflight_q;

  // Shift-in of the issue token; the top bit falls off as the capture strobe.
  assign vld_nxt = (vld_sr << 1) | LATENCY'(fire);

  // ---- stage: issue token pipeline (mirrors the core's latency) ----
  // Token shift register and its population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr     <= '0;
      inflight_q <= '0;
    end else begin
      vld_sr <= vld_nxt;
      // Guard the decrement so a token that never went through issue cannot wrap the count.
      if (fire && !cap)
        inflight_q <= inflight_q + IW'(1);
      else if (!fire && cap && inflight_q != '0)
        inflight_q <= inflight_q - IW'(1);
    end
  end

  // ---- stage: capture into result FIFO ----
  // FIFO storage holds data only; validity lives in the pointers and count.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= core_r;
  end

  // FIFO pointers and occupancy; simultaneous capture and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (wr && !pop)
        cnt <= cnt + CW'(1);
      else if (!wr && pop)
        cnt <= cnt - CW'(1);
    end
  end

  // NaN statistics on stored results and sticky overflow on a dropped capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr && cap_nan)
        nan_count <= sat_inc16(nan_count);
      if (cap && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flopoco_fadd_result_capture.sv
// Bench for flopoco_fadd_result_capture: a behavioural fadd stand-in that
// delays a chosen result by LATENCY cycles, plus a queue-based reference of
// issued results (each tagged with the cycle it must become visible).
module tb_flopoco_fadd_result_capture;

  localparam int WE = 4;
  localparam int WF = 4;
  localparam int W  = WE + WF + 3;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int IW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  core_r;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_exn;
  logic [IW-1:0] inflight;
  logic [15:0]   nan_count;
  logic          overflow;

  logic [W-1:0]  issue_r;
  logic [W-1:0]  cpipe [L];

  typedef struct {
    logic [W-1:0] d;
    int           avail;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    nan_m = 0;
  bit    ovf_m = 0;
  bit    mon_en = 1;
  int    n_checks = 0;
  int    n_errors = 0;
  int    infl_m;
  bit    ov_m;

  flopoco_fadd_result_capture #(
    .WE(WE), .WF(WF), .W(W), .LATENCY(L), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .core_r(core_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_exn(out_exn), .inflight(inflight),
    .nan_count(nan_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Core stand-in: whatever result is presented with the operands appears on R L cycles later.
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) cpipe[i] <= cpipe[i-1];
    cpipe[0] <= issue_r;
  end
  assign core_r = cpipe[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a result fired in cycle c is visible from cycle c+L+1 until popped.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      nan_m = 0;
      ovf_m = 0;
      if (mon_en) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_inflight", inflight, 0);
        check("rst_in_ready", in_ready, 1);
      end
    end else if (mon_en) begin
      infl_m = 0;
      foreach (q[i]) begin
        if (q[i].avail == cyc && q[i].d[W-1:W-2] == 2'b11 && nan_m < 65535) nan_m++;
        if (q[i].avail > cyc) infl_m++;
      end
      ov_m = (q.size() > 0) && (q[0].avail <= cyc);
      check("in_ready", in_ready, (q.size() < D));
      check("inflight", inflight, infl_m);
      check("out_valid", out_valid, ov_m);
      if (ov_m) begin
        check("out_data", out_data, q[0].d);
        check("out_exn", out_exn, q[0].d[W-1:W-2]);
      end
      check("nan_count", nan_count, nan_m);
      check("overflow", overflow, ovf_m);
      if (in_valid && q.size() < D) q.push_back('{issue_r, cyc + L + 1});
      if (ov_m && out_ready) void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int base;
    logic [W-1:0] head;
    logic [1:0] exns [4];
    rst_n = 0; in_valid = 0; out_ready = 0; issue_r = '0;
    repeat (2) step();
    check("reset_nan", nan_count, 0);
    check("reset_ovf", overflow, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1;
    step();

    // 1: single issue, 1.0 + 1.0 -> 2.0 visible L+1 cycles after fire
    in_valid = 1; issue_r = 11'h280;
    step();
    in_valid = 0; issue_r = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin step(); lat++; end
    check("t1_latency", lat, L + 1);
    check("t1_data", out_data, 11'h280);
    check("t1_exn", out_exn, 2'b01);
    out_ready = 1; step(); out_ready = 0;
    check("t1_empty", out_valid, 0);

    // 2: eight back-to-back with the consumer stalled, then one refused fire
    for (int i = 0; i < D; i++) begin
      in_valid = 1; issue_r = W'($urandom);
      step();
    end
    check("t2_in_ready_low", in_ready, 0);
    issue_r = 11'h7FF;
    step();
    in_valid = 0;
    repeat (L + 2) step();
    check("t2_no_overflow", overflow, 0);
    check("t2_full_valid", out_valid, 1);
    out_ready = 1;
    repeat (D) step();
    check("t2_drained", out_valid, 0);
    out_ready = 0;

    // 3: steady streaming
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      issue_r = W'($urandom);
      step();
      if (i > 10) begin
        check("t3_inflight", inflight, L);
        check("t3_in_ready", in_ready, 1);
      end
    end
    in_valid = 0;
    repeat (L + 3) step();
    out_ready = 0;

    // 4: exception decode and NaN counting
    base = nan_m;
    exns = '{2'b11, 2'b11, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; issue_r = (i < 3) ? 11'h600 : 11'h400;
      step();
    end
    in_valid = 0;
    repeat (L + 2) step();
    check("t4_nan_count", nan_count, base + 3);
    for (int i = 0; i < 4; i++) begin
      check("t4_exn", out_exn, exns[i]);
      out_ready = 1; step(); out_ready = 0;
    end

    // random traffic
    for (int i = 0; i < 150; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); issue_r = W'($urandom);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (L + D + 4) step();
    out_ready = 0;

    // 5: capture strobe forced onto a full FIFO
    for (int i = 0; i < D; i++) begin
      in_valid = 1; issue_r = {2'b01, 9'($urandom)};
      step();
    end
    in_valid = 0;
    repeat (L + 2) step();
    head = q[0].d;
    mon_en = 0;
    force dut.vld_sr = 4'b1000;
    step();
    release dut.vld_sr;
    repeat (L + 1) step();
    check("t5_overflow", overflow, 1);
    check("t5_head", out_data, head);
    check("t5_in_ready", in_ready, 0);
    check("t5_inflight", inflight, 0);
    ovf_m = 1;
    mon_en = 1;
    out_ready = 1;
    repeat (D) step();
    check("t5_drained", out_valid, 0);
    out_ready = 0;

    // 6: reset with three in flight and two queued
    in_valid = 1; issue_r = 11'h2A1; step();
    issue_r = 11'h2A2; step();
    in_valid = 0; step();
    in_valid = 1; issue_r = 11'h2A3; step();
    issue_r = 11'h2A4; step();
    issue_r = 11'h2A5; step();
    in_valid = 0;
    check("t6_inflight_pre", inflight, 3);
    check("t6_queued_pre", out_valid, 1);
    #1 rst_n = 0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_inflight", inflight, 0);
    check("t6_in_ready", in_ready, 1);
    step();
    rst_n = 1;
    repeat (L + 4) step();
    check("t6_no_stale", out_valid, 0);
    in_valid = 1; issue_r = 11'h281; step();
    in_valid = 0;
    repeat (L + 1) step();
    check("t6_after_data", out_data, 11'h281);
    out_ready = 1; step(); out_ready = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
